// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes
// and the datapath mux/ALU select codes driven by the controller.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALR2    = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

endpackage

// File: rtl/ctrl_opdec.sv
// Combinational opcode decode: the state that follows DECODE and the
// immediate format selected for the current instruction.
import riscv_ctrl_pkg::*;

module ctrl_opdec (
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  output state_t     o_decode_next,
  output logic [2:0] o_imm_src
);

  // Next-state after DECODE; only BEQ/BNE are supported branch kinds.
  always_comb begin
    o_decode_next = S_ILLEGAL;
    case (i_op)
      OP_LOAD, OP_STORE: o_decode_next = S_MEMADR;
      OP_RTYPE:          o_decode_next = S_EXECR;
      OP_ITYPE:          o_decode_next = S_EXECI;
      OP_BRANCH: begin
        if ((i_funct3 == 3'b000) || (i_funct3 == 3'b001)) begin
          o_decode_next = S_BRANCH;
        end else begin
          o_decode_next = S_ILLEGAL;
        end
      end
      OP_JAL:            o_decode_next = S_JAL;
      OP_JALR:           o_decode_next = S_JALR;
      OP_LUI:            o_decode_next = S_LUI;
      OP_AUIPC:          o_decode_next = S_AUIPC;
      default:           o_decode_next = S_ILLEGAL;
    endcase
  end

  // Immediate format select from the opcode alone.
  always_comb begin
    o_imm_src = IMM_I;
    case (i_op)
      OP_LOAD, OP_ITYPE, OP_JALR: o_imm_src = IMM_I;
      OP_STORE:                   o_imm_src = IMM_S;
      OP_BRANCH:                  o_imm_src = IMM_B;
      OP_LUI, OP_AUIPC:           o_imm_src = IMM_U;
      OP_JAL:                     o_imm_src = IMM_J;
      default:                    o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM with a retired-instruction counter.
// Strobes are decoded from the state register and forced low during reset.
import riscv_ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 Zero,
  input  logic                 mem_ready,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [2:0]           ImmSrc,
  output logic                 Illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t                r_state;
  logic [INSTRET_W-1:0]  r_instret;
  state_t                w_decode_next;
  logic [2:0]            w_imm_src;
  logic                  w_retire;
  logic                  w_mem_req;
  logic                  w_mem_write;
  logic                  w_ir_write;
  logic                  w_pc_write;
  logic                  w_reg_write;

  ctrl_opdec u_opdec (
    .i_op          (op),
    .i_funct3      (funct3),
    .o_decode_next (w_decode_next),
    .o_imm_src     (w_imm_src)
  );

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) ||
                    (r_state == S_BRANCH) ||
                    ((r_state == S_MEMWRITE) && mem_ready);

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
    end else begin
      if (w_retire) begin
        r_instret <= r_instret + INSTRET_W'(1);
      end
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE:   r_state <= w_decode_next;
        S_MEMADR:   r_state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) r_state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) r_state <= S_FETCH;
        S_MEMWB, S_ALUWB, S_BRANCH: r_state <= S_FETCH;
        S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_JAL, S_JALR2: r_state <= S_ALUWB;
        S_JALR:     r_state <= S_JALR2;
        S_ILLEGAL:  r_state <= S_ILLEGAL;
        default:    r_state <= S_ILLEGAL;
      endcase
    end
  end

  // Datapath control decode; FETCH completion and BRANCH PCWrite also look at inputs.
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          ALUSrcA    = SRCA_PC;
          ALUSrcB    = SRCB_FOUR;
          ALUOp      = ALUOP_ADD;
          ResultSrc  = RES_ALURESULT;
        end else begin
          w_ir_write = 1'b0;
        end
      end
      S_DECODE:   begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
      S_MEMADR:   begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_IMM; end
      S_MEMREAD:  begin w_mem_req = 1'b1; AdrSrc = 1'b1; end
      S_MEMWB:    begin ResultSrc = RES_MEMDATA; w_reg_write = 1'b1; end
      S_MEMWRITE: begin w_mem_req = 1'b1; w_mem_write = 1'b1; AdrSrc = 1'b1; end
      S_EXECR:    begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_RS2; ALUOp = ALUOP_RTYPE; end
      S_EXECI:    begin ALUSrcA = SRCA_RS1; ALUSrcB = SRCB_IMM; ALUOp = ALUOP_ITYPE; end
      S_ALUWB:    begin ResultSrc = RES_ALUOUT; w_reg_write = 1'b1; end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUOp      = ALUOP_SUB;
        w_pc_write = Zero ^ funct3[0];
      end
      S_JAL, S_JALR2: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        w_pc_write = 1'b1;
      end
      S_JALR:     begin ALUSrcA = SRCA_RS1;   ALUSrcB = SRCB_IMM; end
      S_LUI:      begin ALUSrcA = SRCA_ZERO;  ALUSrcB = SRCB_IMM; end
      S_AUIPC:    begin ALUSrcA = SRCA_OLDPC; ALUSrcB = SRCB_IMM; end
      S_ILLEGAL:  w_mem_req = 1'b0;
      default:    w_mem_req = 1'b0;
    endcase
  end

  assign MemReq   = w_mem_req   & ~reset;
  assign MemWrite = w_mem_write & ~reset;
  assign IRWrite  = w_ir_write  & ~reset;
  assign PCWrite  = w_pc_write  & ~reset;
  assign RegWrite = w_reg_write & ~reset;
  assign ImmSrc   = w_imm_src;
  assign Illegal  = (r_state == S_ILLEGAL);
  assign instret  = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed per-cycle bench: stimulus pushes hand-computed expected controls
// into a scoreboard queue; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] JAL  = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = ADD;
  logic [2:0] funct3 = 3'b000;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] instret;

  typedef struct {
    string       tag;
    logic [17:0] ctl;
    logic [3:0]  ir;
  } exp_t;

  exp_t scb[$];
  int   total = 0;
  int   bad   = 0;

  multicycle_ctrl #(.INSTRET_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero),
    .mem_ready(mem_ready), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // Packed control vector {MemReq,MemWrite,AdrSrc,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,Illegal}
  function automatic logic [17:0] cv(input logic mreq, input logic mw, input logic adr,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sbb, input logic [1:0] aop,
                                     input logic [2:0] imm, input logic ill);
    return {mreq, mw, adr, irw, pcw, rw, rs, sa, sbb, aop, imm, ill};
  endfunction

  function automatic logic [17:0] v_fetch(input logic [2:0] imm);
    return cv(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, imm, 1'b0);
  endfunction

  function automatic logic [17:0] v_decode(input logic [2:0] imm);
    return cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, imm, 1'b0);
  endfunction

  function automatic logic [17:0] v_aluwb(input logic [2:0] imm);
    return cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, imm, 1'b0);
  endfunction

  function automatic logic [17:0] v_memadr(input logic [2:0] imm);
    return cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, imm, 1'b0);
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic [6:0] o,
                     input logic [2:0] f3, input logic z, input logic rdy,
                     input logic [17:0] c, input logic [3:0] ir);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; op = o; funct3 = f3; Zero = z; mem_ready = rdy;
    e.tag = tag; e.ctl = c; e.ir = ir;
    scb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [17:0] act;
    if (scb.size() != 0) begin
      e   = scb.pop_front();
      act = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, Illegal};
      total++;
      if (act !== e.ctl || instret !== e.ir) begin
        bad++;
        $display("FAIL %s: got ctl=%b instret=%0d, want ctl=%b instret=%0d",
                 e.tag, act, instret, e.ctl, e.ir);
      end
    end
  end

  initial begin
    int waits;
    cyc("reset", 1'b1, ADD, 3'b000, 1'b0, 1'b0, 18'd0, 4'd0);

    // ADD with memory always ready
    cyc("add_fetch",  1'b0, ADD, 3'b000, 1'b0, 1'b1, v_fetch(3'b000), 4'd0);
    cyc("add_decode", 1'b0, ADD, 3'b000, 1'b0, 1'b1, v_decode(3'b000), 4'd0);
    cyc("add_execr",  1'b0, ADD, 3'b000, 1'b0, 1'b1,
        cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0), 4'd0);
    cyc("add_aluwb",  1'b0, ADD, 3'b000, 1'b0, 1'b1, v_aluwb(3'b000), 4'd0);

    // Load with a three-cycle memory stall
    cyc("lw_fetch",  1'b0, LW, 3'b010, 1'b0, 1'b1, v_fetch(3'b000), 4'd1);
    cyc("lw_decode", 1'b0, LW, 3'b010, 1'b0, 1'b1, v_decode(3'b000), 4'd1);
    cyc("lw_memadr", 1'b0, LW, 3'b010, 1'b0, 1'b0, v_memadr(3'b000), 4'd1);
    for (int i = 0; i < 4; i++) begin
      cyc("lw_memread", 1'b0, LW, 3'b010, 1'b0, (i == 3) ? 1'b1 : 1'b0,
          cv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0), 4'd1);
    end
    cyc("lw_memwb", 1'b0, LW, 3'b010, 1'b0, 1'b0,
        cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0), 4'd1);

    // Store, one stall cycle, retires in the ready cycle
    cyc("sw_fetch",  1'b0, SW, 3'b010, 1'b0, 1'b1, v_fetch(3'b001), 4'd2);
    cyc("sw_decode", 1'b0, SW, 3'b010, 1'b0, 1'b0, v_decode(3'b001), 4'd2);
    cyc("sw_memadr", 1'b0, SW, 3'b010, 1'b0, 1'b0, v_memadr(3'b001), 4'd2);
    cyc("sw_memwr_wait", 1'b0, SW, 3'b010, 1'b0, 1'b0,
        cv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0), 4'd2);
    cyc("sw_memwr_done", 1'b0, SW, 3'b010, 1'b0, 1'b1,
        cv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0), 4'd2);

    // BEQ taken then BNE not taken, both with Zero=1
    cyc("beq_fetch",  1'b0, BR, 3'b000, 1'b1, 1'b1, v_fetch(3'b010), 4'd3);
    cyc("beq_decode", 1'b0, BR, 3'b000, 1'b1, 1'b1, v_decode(3'b010), 4'd3);
    cyc("beq_branch", 1'b0, BR, 3'b000, 1'b1, 1'b1,
        cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 1'b0), 4'd3);
    cyc("bne_fetch",  1'b0, BR, 3'b001, 1'b1, 1'b1, v_fetch(3'b010), 4'd4);
    cyc("bne_decode", 1'b0, BR, 3'b001, 1'b1, 1'b1, v_decode(3'b010), 4'd4);
    cyc("bne_branch", 1'b0, BR, 3'b001, 1'b1, 1'b1,
        cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 3'b010, 1'b0), 4'd4);

    // JALR: only the final ALUWB retires
    cyc("jalr_fetch",  1'b0, JALR, 3'b000, 1'b0, 1'b1, v_fetch(3'b000), 4'd5);
    cyc("jalr_decode", 1'b0, JALR, 3'b000, 1'b0, 1'b1, v_decode(3'b000), 4'd5);
    cyc("jalr_1", 1'b0, JALR, 3'b000, 1'b0, 1'b1, v_memadr(3'b000), 4'd5);
    cyc("jalr_2", 1'b0, JALR, 3'b000, 1'b0, 1'b1,
        cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0), 4'd5);
    cyc("jalr_aluwb", 1'b0, JALR, 3'b000, 1'b0, 1'b1, v_aluwb(3'b000), 4'd5);

    cyc("jal_fetch",  1'b0, JAL, 3'b000, 1'b0, 1'b1, v_fetch(3'b100), 4'd6);
    cyc("jal_decode", 1'b0, JAL, 3'b000, 1'b0, 1'b0, v_decode(3'b100), 4'd6);
    cyc("jal_jal", 1'b0, JAL, 3'b000, 1'b0, 1'b0,
        cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 3'b100, 1'b0), 4'd6);
    cyc("jal_aluwb", 1'b0, JAL, 3'b000, 1'b0, 1'b0, v_aluwb(3'b100), 4'd6);

    // Reset while a store request is pending
    cyc("sw2_fetch",  1'b0, SW, 3'b010, 1'b0, 1'b1, v_fetch(3'b001), 4'd7);
    cyc("sw2_decode", 1'b0, SW, 3'b010, 1'b0, 1'b0, v_decode(3'b001), 4'd7);
    cyc("sw2_memadr", 1'b0, SW, 3'b010, 1'b0, 1'b0, v_memadr(3'b001), 4'd7);
    cyc("sw2_memwr_wait", 1'b0, SW, 3'b010, 1'b0, 1'b0,
        cv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0), 4'd7);
    cyc("rst_in_memwrite", 1'b1, SW, 3'b010, 1'b0, 1'b0,
        cv(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0), 4'd7);
    cyc("post_rst_fetch", 1'b0, SW, 3'b010, 1'b0, 1'b0,
        cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0), 4'd0);

    // 16 ADDIs wrap the 4-bit counter back to 0
    for (int k = 0; k < 16; k++) begin
      cyc("addi_fetch",  1'b0, ADDI, 3'b000, 1'b0, 1'b1, v_fetch(3'b000), 4'(k));
      cyc("addi_decode", 1'b0, ADDI, 3'b000, 1'b0, 1'b1, v_decode(3'b000), 4'(k));
      cyc("addi_execi",  1'b0, ADDI, 3'b000, 1'b0, 1'b1,
          cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b11, 3'b000, 1'b0), 4'(k));
      cyc("addi_aluwb",  1'b0, ADDI, 3'b000, 1'b0, 1'b1, v_aluwb(3'b000), 4'(k));
    end

    // Unsupported branch funct3 locks into ILLEGAL until reset
    cyc("ill_fetch",  1'b0, BR, 3'b100, 1'b1, 1'b1, v_fetch(3'b010), 4'd0);
    cyc("ill_decode", 1'b0, BR, 3'b100, 1'b1, 1'b1, v_decode(3'b010), 4'd0);
    for (int i = 0; i < 3; i++) begin
      cyc("ill_hold", 1'b0, BR, 3'b100, 1'b1, 1'b1,
          cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b010, 1'b1), 4'd0);
    end
    cyc("ill_sticky", 1'b0, ADD, 3'b000, 1'b0, 1'b1,
        cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1), 4'd0);
    cyc("ill_rst", 1'b1, ADD, 3'b000, 1'b0, 1'b0,
        cv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1), 4'd0);
    cyc("ill_cleared", 1'b0, ADD, 3'b000, 1'b0, 1'b0,
        cv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0), 4'd0);

    waits = 0;
    while (scb.size() != 0 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    #1;
    if (scb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending checks, want 0", scb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
